latch_write_arbiter: RTL and testbench
======================================

# latch_write_arbiter

Shares a bank of load-enabled, clear-able N-bit output latches between two bus masters. Requester A is the Z80/S100 I/O write path and requester B is the on-board monitor/SD boot sequencer. The block accepts one write at a time over a four-phase req/ack handshake. For each write it registers the data and address, issues a single-cycle one-hot load strobe to the addressed latch, and acknowledges. It sits between the I/O decode logic and the latch bank, and drives each latch's load and data inputs.

## Interface
- N, 8, data width of each latch.
- REGS, 4, number of latches in the bank (1..16).
- AW, 2, address width; REGS ≤ 2**AW.
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- a_req  in  1  requester A write request (level, four-phase).
- a_addr  in  AW  requester A latch index.
- a_data  in  N  requester A write data.
- a_ack  out  1  requester A acknowledge.
- b_req  in  1  requester B write request.
- b_addr  in  AW  requester B latch index.
- b_data  in  N  requester B write data.
- b_ack  out  1  requester B acknowledge.
- load  out  REGS  one-hot load strobes to the latch bank, registered.
- wdata  out  N  shared write data to all latches, registered.
- busy  out  1  high in any state other than IDLE.
- addr_err  out  1  sticky flag: a write targeted an index ≥ REGS.

## Operation
- The FSM has three states: IDLE, LOAD and ACK.
- IDLE:
  - If any req is high, pick a winner, capture its addr and data, and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - load[addr] = 1 for exactly this one cycle; all other load bits are 0.
  - wdata = captured data.
  - Go to ACK.
- ACK:
  - The winner's ack = 1.
  - Stay in ACK while the winner's req = 1.
  - When the winner's req = 0 is sampled, drop ack and go to IDLE.
- Arbitration:
  - Applies only when both reqs are high in IDLE. The requester not served last wins.
  - After reset, A has priority.
  - The last-served pointer updates on every grant.
- A loser's req stays pending; no ack is issued to it. It is granted from IDLE after the current transaction completes.
- Out-of-range address (addr ≥ REGS):
  - The transaction runs normally with all load bits 0.
  - ack is still given.
  - addr_err is set; it is cleared only by clr.
- wdata holds its value after LOAD until the next LOAD, so the latch data input stays stable.
- Requesters must keep addr and data stable while req is high. The arbiter samples them only at the grant edge.
- Reset (clr low), at any time including mid-transaction:
  - Outputs: load = 0, wdata = 0, a_ack = b_ack = 0, busy = 0, addr_err = 0.
  - State = IDLE, priority = A.
  - An in-flight write is abandoned. Its load pulse is suppressed if it has not yet been issued, and the requester must restart the handshake.

## Timing
- E0 is the rising edge that samples req = 1 in IDLE. After E0: load and wdata are valid and busy = 1.
- E1: the latch captures wdata. After E1: load = 0 and ack = 1.
- ack falls at the first edge that samples the winner's req = 0. busy falls at the same edge.
- A new grant is possible at the next edge.
- Minimum transaction length is 3 cycles (req sampled → ack → release sampled). Back-to-back writes from alternating requesters have a throughput of one write per 3 cycles.
- A requester that drops req before ack (protocol violation) is still granted if it was sampled at E0. Its ACK phase lasts one cycle.
- All outputs are registered; there are no combinational paths from req to ack or load.

## Configuration
- Macro: LATCH_ARB_RR_EN.
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority, with A always winning simultaneous requests. The last-served pointer is removed, and B can starve while A requests continuously.

## Structure
- Package latch_arb_pkg holds:
  - the state typedef (IDLE, LOAD, ACK) with binary encoding;
  - localparams for the default N, REGS and AW;
  - the requester-select encoding (SEL_A = 0, SEL_B = 1).
- Sub-module latch_addr_decode: registered-input one-hot decoder from AW-bit address plus enable to a REGS-bit load vector. It also produces an out_of_range flag.

## Test plan
- Reset mid-LOAD:
  - Stimulus: assert clr low in the cycle load = 4'b0100.
  - Required: load = 0, ack = 0, wdata = 0 immediately; busy = 0.
  - After reset release, a new A request succeeds.
- Single write:
  - Stimulus: A writes addr 2, data 8'hA5.
  - Required: load = 4'b0100 for exactly 1 cycle after E0 with wdata = 8'hA5; a_ack high after E1; a_ack low one edge after a_req drops.
- Simultaneous requests:
  - Stimulus: A (addr 0, 8'h11) and B (addr 3, 8'h33) both request from reset, repeated twice.
  - Required with LATCH_ARB_RR_EN: grants in the order A, B, A, B; load sequence 0001, 1000, 0001, 1000.
  - Required without the macro: A is served first on both rounds; B is served only once A has deasserted.
- Out of range:
  - Stimulus: REGS = 3, B writes addr 3.
  - Required: load stays 3'b000; b_ack is given; addr_err = 1 and stays 1 until clr.
- Data hold:
  - Stimulus: write 8'h5A to addr 1, then idle 10 cycles.
  - Required: wdata = 8'h5A throughout; no load pulses.

Source files
------------

// File: rtl/latch_arb_pkg.sv
// Shared types and defaults for the two-master latch write arbiter.
// Holds the FSM state encoding, requester select encoding and the winner pick helper.
package latch_arb_pkg;

   localparam int DEF_N    = 8;
   localparam int DEF_REGS = 4;
   localparam int DEF_AW   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ACK  = 2'd2
   } arb_state_t;

   typedef enum logic {
      SEL_A = 1'b0,
      SEL_B = 1'b1
   } req_sel_t;

   // Only meaningful when at least one request is up; on a tie the
   // requester not served last wins, unless rotation is disabled.
   function automatic req_sel_t pick_winner(input logic a, input logic b,
                                            input req_sel_t last, input logic rr_en);
      if (a && b)
         return (rr_en && (last == SEL_A)) ? SEL_B : SEL_A;
      return b ? SEL_B : SEL_A;
   endfunction

endpackage

// File: rtl/latch_addr_decode.sv
// Samples address + enable at the grant edge and drives a registered one-hot
// load vector, plus a registered pulse when the address is beyond the bank.
module latch_addr_decode
   import latch_arb_pkg::*;
#(
   parameter int AW   = DEF_AW,
   parameter int REGS = DEF_REGS
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            en,
   input  logic [AW-1:0]   addr,
   output logic [REGS-1:0] load,
   output logic            out_of_range
);

   logic [REGS-1:0] hit;
   logic            oor;

   always_comb begin
      hit = '0;
      for (int i = 0; i < REGS; i++)
         hit[i] = en && (addr == AW'(i));
      oor = en && (int'(addr) >= REGS);
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         load         <= '0;
         out_of_range <= 1'b0;
      end else begin
         load         <= hit;
         out_of_range <= oor;
      end
   end

endmodule

// File: rtl/latch_write_arbiter.sv
// Two-master write arbiter for a bank of load-enabled latches (A = Z80/S100 I/O, B = boot sequencer).
// Define LATCH_ARB_RR_EN for round-robin ties; otherwise A always wins ties.
module latch_write_arbiter
   import latch_arb_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int REGS = DEF_REGS,
   parameter int AW   = DEF_AW
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            a_req,
   input  logic [AW-1:0]   a_addr,
   input  logic [N-1:0]    a_data,
   output logic            a_ack,
   input  logic            b_req,
   input  logic [AW-1:0]   b_addr,
   input  logic [N-1:0]    b_data,
   output logic            b_ack,
   output logic [REGS-1:0] load,
   output logic [N-1:0]    wdata,
   output logic            busy,
   output logic            addr_err,
   output arb_state_t      state_dbg
);

   // Handshake: four-phase. A requester raises req with addr/data stable,
   // sees ack after its load strobe, drops req, and ack falls at the first
   // edge that samples req low. A new grant can happen on the following edge.

   arb_state_t    state;
   req_sel_t      sel;
   req_sel_t      win;
   logic          grant;
   logic          oor_pulse;
   logic [AW-1:0] gaddr;

`ifdef LATCH_ARB_RR_EN
   req_sel_t last;
   assign win = pick_winner(a_req, b_req, last, 1'b1);
`else
   assign win = pick_winner(a_req, b_req, SEL_A, 1'b0);
`endif

   assign grant     = (state == IDLE) && (a_req || b_req);
   assign gaddr     = (win == SEL_B) ? b_addr : a_addr;
   assign state_dbg = state;

   latch_addr_decode #(
      .AW   (AW),
      .REGS (REGS)
   ) u_decode (
      .clk          (clk),
      .clr          (clr),
      .en           (grant),
      .addr         (gaddr),
      .load         (load),
      .out_of_range (oor_pulse)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= IDLE;
         sel      <= SEL_A;
         wdata    <= '0;
         a_ack    <= 1'b0;
         b_ack    <= 1'b0;
         busy     <= 1'b0;
         addr_err <= 1'b0;
`ifdef LATCH_ARB_RR_EN
         last     <= SEL_B;
`endif
      end else begin
         if (oor_pulse)
            addr_err <= 1'b1;
         case (state)
            IDLE: begin
               if (grant) begin
                  sel   <= win;
                  wdata <= (win == SEL_B) ? b_data : a_data;
                  busy  <= 1'b1;
                  state <= LOAD;
`ifdef LATCH_ARB_RR_EN
                  last  <= win;
`endif
               end
            end
            LOAD: begin
               a_ack <= (sel == SEL_A);
               b_ack <= (sel == SEL_B);
               state <= ACK;
            end
            ACK: begin
               if (!((sel == SEL_B) ? b_req : a_req)) begin
                  a_ack <= 1'b0;
                  b_ack <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               a_ack <= 1'b0;
               b_ack <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: a 4-latch and a 3-latch instance share one stimulus stream.
// Table vectors, hand sequences for reset/out-of-range/hold, then random traffic against a model.
module tb_latch_write_arbiter;
   import latch_arb_pkg::*;

`ifdef LATCH_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       a_req = 1'b0, b_req = 1'b0;
   logic [1:0] a_addr = '0, b_addr = '0;
   logic [7:0] a_data = '0, b_data = '0;

   logic [3:0] load4;
   logic [2:0] load3;
   logic [7:0] wdata4, wdata3;
   logic       a_ack4, b_ack4, a_ack3, b_ack3;
   logic       busy4, busy3, err4, err3;
   arb_state_t st4, st3;

   int n_pass  = 0;
   int n_total = 0;
   int k       = 0;

   always #5 clk = ~clk;

   latch_write_arbiter #(.N(8), .REGS(4), .AW(2)) u_dut4 (
      .clk(clk), .clr(clr),
      .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack4),
      .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack4),
      .load(load4), .wdata(wdata4), .busy(busy4), .addr_err(err4), .state_dbg(st4)
   );

   latch_write_arbiter #(.N(8), .REGS(3), .AW(2)) u_dut3 (
      .clk(clk), .clr(clr),
      .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack3),
      .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack3),
      .load(load3), .wdata(wdata3), .busy(busy3), .addr_err(err3), .state_dbg(st3)
   );

   typedef struct {
      logic       c;
      logic       ar;
      logic [1:0] aa;
      logic [7:0] ad;
      logic       br;
      logic [1:0] ba;
      logic [7:0] bd;
      logic [3:0] e_load;
      logic [7:0] e_wd;
      logic       e_aa;
      logic       e_ba;
      logic       e_busy;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic c, input logic ar, input logic [1:0] aa,
                               input logic [7:0] ad, input logic br, input logic [1:0] ba,
                               input logic [7:0] bd, input logic [3:0] el, input logic [7:0] ew,
                               input logic eaa, input logic eba, input logic eb);
      vec_t v;
      v.c = c; v.ar = ar; v.aa = aa; v.ad = ad; v.br = br; v.ba = ba; v.bd = bd;
      v.e_load = el; v.e_wd = ew; v.e_aa = eaa; v.e_ba = eba; v.e_busy = eb;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, k);
   endtask

   // Reference model: one write in flight at a time, described by who owns it,
   // the cycle it was granted and what it carries.
   bit         mb[2], mw[2], mo[2], merr[2], mlast[2];
   int         mg[2];
   logic [1:0] madr[2];
   logic [7:0] mwd[2];
   int         regs_n[2] = '{4, 3};

   task automatic m_reset();
      for (int i = 0; i < 2; i++) begin
         mb[i] = 0; mw[i] = 0; mo[i] = 0; merr[i] = 0; mlast[i] = 1;
         mg[i] = 0; madr[i] = '0; mwd[i] = '0;
      end
   endtask

   task automatic m_step(input int i, input bit ar, input bit br, input logic [1:0] aa,
                         input logic [1:0] ba, input logic [7:0] ad, input logic [7:0] bd);
      bit win, wreq;
      if (mb[i]) begin
         if (k == mg[i] + 1 && mo[i]) merr[i] = 1;
         wreq = mw[i] ? br : ar;
         if (k >= mg[i] + 2 && !wreq) mb[i] = 0;
      end else if (ar || br) begin
         if (ar && br) win = RR ? !mlast[i] : 1'b0;
         else          win = br;
         mb[i]   = 1;
         mw[i]   = win;
         mg[i]   = k;
         madr[i] = win ? ba : aa;
         mwd[i]  = win ? bd : ad;
         mo[i]   = int'(madr[i]) >= regs_n[i];
         mlast[i] = win;
      end
   endtask

   function automatic logic [19:0] m_expect(input int i);
      logic [1:0] st;
      logic [3:0] ld;
      st = !mb[i] ? 2'(IDLE) : (k == mg[i]) ? 2'(LOAD) : 2'(ACK);
      ld = (mb[i] && k == mg[i] && !mo[i]) ? (4'b0001 << madr[i]) : 4'b0000;
      return {st, ld, mwd[i], mb[i] && k >= mg[i] + 1 && !mw[i],
              mb[i] && k >= mg[i] + 1 && mw[i], mb[i], merr[i]};
   endfunction

   bit         rq[2];
   logic [1:0] rad[2];
   logic [7:0] rdt[2];
   int         cool[2];

   initial begin
      // Single write, reset, simultaneous rounds, then a tie right after A is served.
      tbl.push_back(mk(1,1,2,8'hA5, 0,0,8'h00, 4'b0100,8'hA5,0,0,1));
      tbl.push_back(mk(1,1,2,8'hA5, 0,0,8'h00, 4'b0000,8'hA5,1,0,1));
      tbl.push_back(mk(1,1,2,8'hA5, 0,0,8'h00, 4'b0000,8'hA5,1,0,1));
      tbl.push_back(mk(1,0,2,8'hA5, 0,0,8'h00, 4'b0000,8'hA5,0,0,0));
      tbl.push_back(mk(1,0,0,8'h00, 0,0,8'h00, 4'b0000,8'hA5,0,0,0));
      tbl.push_back(mk(0,0,0,8'h00, 0,0,8'h00, 4'b0000,8'h00,0,0,0));
      for (int r = 0; r < 2; r++) begin
         tbl.push_back(mk(1,1,0,8'h11, 1,3,8'h33, 4'b0001,8'h11,0,0,1));
         tbl.push_back(mk(1,1,0,8'h11, 1,3,8'h33, 4'b0000,8'h11,1,0,1));
         tbl.push_back(mk(1,0,0,8'h11, 1,3,8'h33, 4'b0000,8'h11,0,0,0));
         tbl.push_back(mk(1,0,0,8'h11, 1,3,8'h33, 4'b1000,8'h33,0,0,1));
         tbl.push_back(mk(1,0,0,8'h11, 1,3,8'h33, 4'b0000,8'h33,0,1,1));
         tbl.push_back(mk(1,0,0,8'h11, 0,3,8'h33, 4'b0000,8'h33,0,0,0));
      end
      tbl.push_back(mk(1,1,0,8'h11, 1,3,8'h33, 4'b0001,8'h11,0,0,1));
      tbl.push_back(mk(1,1,0,8'h11, 1,3,8'h33, 4'b0000,8'h11,1,0,1));
      tbl.push_back(mk(1,0,0,8'h11, 1,3,8'h33, 4'b0000,8'h11,0,0,0));
      tbl.push_back(mk(1,1,0,8'h11, 1,3,8'h33, RR ? 4'b1000 : 4'b0001, RR ? 8'h33 : 8'h11,0,0,1));
      tbl.push_back(mk(1,1,0,8'h11, 1,3,8'h33, 4'b0000, RR ? 8'h33 : 8'h11, !RR, RR, 1));
      tbl.push_back(mk(1,0,0,8'h11, 0,3,8'h33, 4'b0000, RR ? 8'h33 : 8'h11,0,0,0));
      tbl.push_back(mk(1,0,0,8'h00, 0,0,8'h00, 4'b0000, RR ? 8'h33 : 8'h11,0,0,0));

      // Power-on reset
      clr = 1'b0;
      tick();
      tick();
      chk("reset4", {st4, load4, wdata4, a_ack4, b_ack4, busy4, err4}, 0);
      chk("reset3", {st3, load3, wdata3, a_ack3, b_ack3, busy3, err3}, 0);
      clr = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         clr = tbl[i].c;
         a_req = tbl[i].ar; a_addr = tbl[i].aa; a_data = tbl[i].ad;
         b_req = tbl[i].br; b_addr = tbl[i].ba; b_data = tbl[i].bd;
         tick();
         chk($sformatf("table row %0d", i), {load4, wdata4, a_ack4, b_ack4, busy4},
             {tbl[i].e_load, tbl[i].e_wd, tbl[i].e_aa, tbl[i].e_ba, tbl[i].e_busy});
      end
      clr = 1'b1;

      // Reset while the load strobe is out
      a_req = 1; a_addr = 2; a_data = 8'hA5; b_req = 0;
      tick();
      chk("midload_pre", load4, 4'b0100);
      #2 clr = 1'b0;
      #1;
      chk("midload_rst", {load4, wdata4, a_ack4, b_ack4, busy4}, 0);
      a_req = 0;
      clr = 1'b1;
      tick();
      chk("midload_idle", {busy4, a_ack4}, 0);
      a_req = 1; a_addr = 1; a_data = 8'h5A;
      tick();
      chk("restart_load", {load4, wdata4}, {4'b0010, 8'h5A});
      tick();
      chk("restart_ack", a_ack4, 1);
      a_req = 0;
      tick();
      chk("restart_rel", {a_ack4, busy4}, 0);

      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold", {load4, wdata4}, {4'b0000, 8'h5A});
      end

      // B writes index 3: beyond the 3-latch bank, valid in the 4-latch one
      clr = 1'b0;
      tick();
      chk("oor_clr", err3, 0);
      clr = 1'b1;
      b_req = 1; b_addr = 3; b_data = 8'hC3;
      tick();
      chk("oor_load", {load3, busy3, wdata3}, {3'b000, 1'b1, 8'hC3});
      chk("inrange_load", load4, 4'b1000);
      tick();
      chk("oor_ack", {b_ack3, err3}, 2'b11);
      chk("inrange_err", err4, 0);
      b_req = 0;
      tick();
      chk("oor_rel", {b_ack3, busy3}, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("oor_sticky", err3, 1);
      end
      clr = 1'b0;
      tick();
      chk("oor_cleared", err3, 0);

      // Random traffic with occasional resets
      for (int r = 0; r < 2; r++) begin
         rq[r] = 0; rad[r] = '0; rdt[r] = '0; cool[r] = 0;
      end
      m_reset();
      for (int c = 0; c < 1500; c++) begin
         bit do_rst;
         do_rst = (c == 0) || ($urandom_range(0, 199) == 0);
         clr    = !do_rst;
         a_req  = rq[0]; a_addr = rad[0]; a_data = rdt[0];
         b_req  = rq[1]; b_addr = rad[1]; b_data = rdt[1];
         tick();
         k++;
         if (do_rst) begin
            m_reset();
         end else begin
            for (int i = 0; i < 2; i++)
               m_step(i, rq[0], rq[1], rad[0], rad[1], rdt[0], rdt[1]);
         end
         chk("rand4", {st4, load4, wdata4, a_ack4, b_ack4, busy4, err4}, m_expect(0));
         chk("rand3", {st3, 1'b0, load3, wdata3, a_ack3, b_ack3, busy3, err3}, m_expect(1));
         for (int r = 0; r < 2; r++) begin
            logic ackr;
            ackr = r ? b_ack4 : a_ack4;
            if (do_rst) begin
               rq[r] = 0;
               cool[r] = $urandom_range(0, 3);
            end else if (rq[r]) begin
               if (ackr || $urandom_range(0, 31) == 0) begin
                  rq[r] = 0;
                  cool[r] = $urandom_range(0, 4);
               end
            end else if (cool[r] > 0) begin
               cool[r]--;
            end else begin
               rq[r]  = 1;
               rad[r] = 2'($urandom_range(0, 3));
               rdt[r] = 8'($urandom_range(0, 255));
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
